// File: rtl/telemeter_system_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// ADDR_W must equal 3 + CH_W of the attached timer.
`timescale 1ns/1ps
interface telemeter_system_multi_timer_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/telemeter_system_multi_timer.sv
// N-channel interval timer on one Avalon-MM slave with a combined irq and a global pending word.
// Optional per-channel prescaler is enabled by defining TELEMETER_TIMER_PRESCALER_EN.
`timescale 1ns/1ps
module telemeter_system_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  telemeter_system_multi_timer_if.slave  bus,
  output logic                           irq
);

  localparam int              HI_W  = CNT_W - 16;
  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);

  logic [CH_W-1:0]   ch_idx;
  logic [2:0]        reg_idx;
  logic              wr_en;
  logic [15:0]       rd_data;

  logic [CNT_W-1:0]  counter [NUM_CH];
  logic [CNT_W-1:0]  period  [NUM_CH];
  logic [CNT_W-1:0]  snap    [NUM_CH];
  logic [3:0]        control [NUM_CH];

  logic [NUM_CH-1:0] running;
  logic [NUM_CH-1:0] to;
  logic [NUM_CH-1:0] zero_q;
  logic [NUM_CH-1:0] force_reload;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] start_wr;
  logic [NUM_CH-1:0] stop_wr;
  logic [NUM_CH-1:0] zero_now;
  logic [NUM_CH-1:0] timeout_evt;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

`ifdef TELEMETER_TIMER_PRESCALER_EN
  logic [7:0]        prescale [NUM_CH];
  logic [7:0]        div      [NUM_CH];
`endif

  assign ch_idx  = bus.address[CH_W+2:3];
  assign reg_idx = bus.address[2:0];
  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign irq     = |pending;

  // Per-channel decode and event detection; timeout is the rising edge of counter == 0.
  always_comb begin
    wr_sel      = '0;
    start_wr    = '0;
    stop_wr     = '0;
    zero_now    = '0;
    timeout_evt = '0;
    tick        = '0;
    pending     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i]      = wr_en && (ch_idx == CH_W'(i));
      start_wr[i]    = wr_sel[i] && (reg_idx == 3'd1) && bus.writedata[2];
      stop_wr[i]     = wr_sel[i] && (reg_idx == 3'd1) && bus.writedata[3];
      zero_now[i]    = (counter[i] == '0);
      timeout_evt[i] = zero_now[i] & ~zero_q[i];
      pending[i]     = to[i] & control[i][0];
`ifdef TELEMETER_TIMER_PRESCALER_EN
      tick[i]        = (div[i] == prescale[i]);
`else
      tick[i]        = 1'b1;
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_W'(i)) begin
        case (reg_idx)
          3'd0: rd_data = {14'd0, running[i], to[i]};
          3'd1: rd_data = {12'd0, control[i]};
          3'd2: rd_data = period[i][15:0];
          3'd3: rd_data = 16'(period[i][CNT_W-1:16]);
          3'd4: rd_data = snap[i][15:0];
          3'd5: rd_data = 16'(snap[i][CNT_W-1:16]);
          3'd6: rd_data = 16'(pending);
`ifdef TELEMETER_TIMER_PRESCALER_EN
          3'd7: rd_data = {8'd0, prescale[i]};
`else
          3'd7: rd_data = '0;
`endif
          default: rd_data = '0;
        endcase
      end
    end
  end

  // START outranks every source of stop; a timeout event outranks a same-cycle status clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      running      <= '0;
      to           <= '0;
      force_reload <= '0;
      zero_q       <= {NUM_CH{RST_P == '0}};
      for (int i = 0; i < NUM_CH; i++) begin
        counter[i]  <= RST_P;
        period[i]   <= RST_P;
        snap[i]     <= '0;
        control[i]  <= '0;
`ifdef TELEMETER_TIMER_PRESCALER_EN
        prescale[i] <= '0;
        div[i]      <= '0;
`endif
      end
    end else begin
      bus.readdata <= rd_data;
      for (int i = 0; i < NUM_CH; i++) begin
        force_reload[i] <= wr_sel[i] && ((reg_idx == 3'd2) || (reg_idx == 3'd3));
        zero_q[i]       <= zero_now[i];

        if (wr_sel[i] && (reg_idx == 3'd1))
          control[i] <= bus.writedata[3:0];
        if (wr_sel[i] && (reg_idx == 3'd2))
          period[i][15:0] <= bus.writedata;
        if (wr_sel[i] && (reg_idx == 3'd3))
          period[i][CNT_W-1:16] <= bus.writedata[HI_W-1:0];
        if (wr_sel[i] && ((reg_idx == 3'd4) || (reg_idx == 3'd5)))
          snap[i] <= counter[i];

        if (force_reload[i])
          counter[i] <= period[i];
        else if (running[i] && tick[i])
          counter[i] <= zero_now[i] ? period[i] : counter[i] - CNT_W'(1);

        if (start_wr[i])
          running[i] <= 1'b1;
        else if (stop_wr[i] || force_reload[i] ||
                 (running[i] && tick[i] && zero_now[i] && !control[i][1]))
          running[i] <= 1'b0;

        if (timeout_evt[i])
          to[i] <= 1'b1;
        else if (wr_sel[i] && (reg_idx == 3'd0))
          to[i] <= 1'b0;

`ifdef TELEMETER_TIMER_PRESCALER_EN
        if (wr_sel[i] && (reg_idx == 3'd7))
          prescale[i] <= bus.writedata[7:0];
        if ((wr_sel[i] && (reg_idx == 3'd7)) || start_wr[i] || force_reload[i])
          div[i] <= '0;
        else if (div[i] == prescale[i])
          div[i] <= '0;
        else
          div[i] <= div[i] + 8'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_telemeter_system_multi_timer.sv
// Directed register-level bench for telemeter_system_multi_timer; expected read and irq
// values go into a scoreboard queue and are popped as the DUT produces them.
`timescale 1ns/1ps
module tb_telemeter_system_multi_timer;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int RP     = 999;
  localparam int AW     = 5;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        irq;
  int          cycle   = 0;
  int          total   = 0;
  int          bad     = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  telemeter_system_multi_timer_if #(.ADDR_W(AW)) bus_if ();

  telemeter_system_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // One bus cycle driven mid-low-phase; readdata sampled 1 ns after the edge.
  task automatic applyStimulus(input bit is_wr, input int ch, input int r,
                               input logic [15:0] data, output logic [15:0] rd);
    @(negedge clk);
    bus_if.address    = AW'((ch << 3) | r);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = ~is_wr;
    bus_if.writedata  = data;
    @(posedge clk);
    #1;
    rd = bus_if.readdata;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic pushExp(input logic [15:0] expv, input string tag);
    exp_q.push_back(expv);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput(input logic [15:0] observed);
    logic [15:0] expv;
    string       tag;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=0x%04h expected=none", observed);
      return;
    end
    expv = exp_q.pop_front();
    tag  = tag_q.pop_front();
    assert (observed === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, observed, expv);
    end
  endtask

  task automatic writeReg(input int ch, input int r, input logic [15:0] data);
    logic [15:0] unused_rd;
    applyStimulus(1'b1, ch, r, data, unused_rd);
  endtask

  task automatic readExpect(input int ch, input int r, input logic [15:0] expv, input string tag);
    logic [15:0] rd;
    pushExp(expv, tag);
    applyStimulus(1'b0, ch, r, 16'h0000, rd);
    checkOutput(rd);
  endtask

  task automatic checkIrq(input logic expv, input string tag);
    pushExp({15'd0, expv}, tag);
    checkOutput({15'd0, irq});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int c1;
    int c2;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIrq(1'b0, "reset_irq");
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    readExpect(0, 0, 16'h0000, "reset_status");
    readExpect(0, 1, 16'h0000, "reset_control");
    readExpect(0, 2, 16'(RP), "reset_period_l");
    readExpect(0, 3, 16'(RP >> 16), "reset_period_h");
    readExpect(2, 4, 16'h0000, "reset_snap_l");
    readExpect(3, 6, 16'h0000, "reset_pending");
    readExpect(1, 7, 16'h0000, "reset_reg7");

    // Continuous ch0 at the reset period: timeout RP+1 clocks after START
    writeReg(0, 1, 16'h0006);
    repeat (RP) @(posedge clk);
    readExpect(0, 0, 16'h0002, "t1_status_before_to");
    writeReg(0, 4, 16'h0000);
    readExpect(0, 0, 16'h0003, "t1_status_to");
    readExpect(0, 4, 16'(RP), "t1_reload_snap_l");
    readExpect(0, 5, 16'(RP >> 16), "t1_reload_snap_h");
    writeReg(0, 0, 16'h0000);
    writeReg(0, 1, 16'h0008);
    readExpect(0, 0, 16'h0000, "t1_stopped_cleared");
    readExpect(0, 1, 16'h0008, "t1_control_rd");

    // One-shot ch2, period 9, irq 10 clocks after START
    writeReg(2, 2, 16'd9);
    writeReg(2, 3, 16'd0);
    writeReg(2, 1, 16'h0005);
    repeat (9) @(posedge clk);
    #1;
    checkIrq(1'b0, "t2_irq_before");
    @(posedge clk);
    #1;
    checkIrq(1'b1, "t2_irq_rise");
    readExpect(2, 0, 16'h0001, "t2_oneshot_stopped");
    readExpect(0, 6, 16'h0004, "t2_pending");
    writeReg(2, 0, 16'h0000);
    checkIrq(1'b0, "t2_irq_drop");

    // ch1 status clear lands on the same edge as its timeout event
    writeReg(1, 2, 16'd4);
    writeReg(1, 1, 16'h0007);
    repeat (4) @(posedge clk);
    writeReg(1, 0, 16'h0000);
    checkIrq(1'b1, "t3_irq_kept");
    readExpect(1, 0, 16'h0003, "t3_to_kept");
    readExpect(1, 6, 16'h0002, "t3_pending");
    writeReg(1, 1, 16'h0008);
    writeReg(1, 0, 16'h0000);
    checkIrq(1'b0, "t3_irq_clear");

    // ch3 snapshot of a running counter at 0x1234
    writeReg(3, 2, 16'h1240);
    writeReg(3, 1, 16'h0006);
    repeat (12) @(posedge clk);
    writeReg(3, 4, 16'h0000);
    readExpect(3, 4, 16'h1234, "t4_snap_l");
    readExpect(3, 5, 16'h0000, "t4_snap_h");

    // Period write while running: reload and stop one clock later; START on that clock wins
    writeReg(3, 2, 16'h0050);
    readExpect(3, 0, 16'h0002, "t5_still_running");
    readExpect(3, 0, 16'h0000, "t5_reload_stopped");
    writeReg(3, 5, 16'h0000);
    readExpect(3, 4, 16'h0050, "t5_reload_value");
    writeReg(3, 2, 16'h0060);
    writeReg(3, 1, 16'h0006);
    readExpect(3, 0, 16'h0002, "t5_start_wins");
    writeReg(3, 4, 16'h0000);
    readExpect(3, 4, 16'h005F, "t5_counting");
    writeReg(3, 1, 16'h0008);

    // Period 0 continuous: timeout once, no retrigger while counter holds 0
    writeReg(1, 2, 16'h0000);
    writeReg(1, 1, 16'h0007);
    @(posedge clk);
    readExpect(1, 0, 16'h0003, "t7_zero_period_to");
    writeReg(1, 0, 16'h0000);
    repeat (10) @(posedge clk);
    readExpect(1, 0, 16'h0002, "t7_no_retrigger");
    writeReg(1, 1, 16'h0008);

`ifdef TELEMETER_TIMER_PRESCALER_EN
    // Prescale 3, period 4, continuous: timeouts 20 clocks apart
    writeReg(0, 7, 16'h0003);
    readExpect(0, 7, 16'h0003, "t6_prescale_rd");
    writeReg(0, 2, 16'd4);
    writeReg(0, 1, 16'h0007);
    n = 0;
    while (!irq && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkIrq(1'b1, "t6_first_to");
    c1 = cycle;
    writeReg(0, 0, 16'h0000);
    n = 0;
    while (!irq && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkIrq(1'b1, "t6_second_to");
    c2 = cycle;
    pushExp(16'd20, "t6_interval");
    checkOutput(16'(c2 - c1));
    writeReg(0, 1, 16'h0008);
    writeReg(0, 0, 16'h0000);
    writeReg(0, 7, 16'h0000);
`else
    n = 0; c1 = 0; c2 = 0;
    writeReg(0, 7, 16'h00FF);
    readExpect(0, 7, 16'h0000, "t6_reg7_absent");
`endif

    checkIrq(1'b0, "final_irq");
    readExpect(2, 6, 16'h0000, "final_pending");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
